// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// Optional macro BIN_TO_BCD_BLANK_EN adds the leading-zero blank vector.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_WIDTH = 8,
    parameter int unsigned DIGITS    = 3
);
    logic                   start;
    logic [BIN_WIDTH-1:0]   bin_in;
    logic                   busy;
    logic                   done;
    logic [4*DIGITS-1:0]    bcd_out;
    logic                   overflow;
`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0]      blank;

    modport master (output start, bin_in, input busy, done, bcd_out, overflow, blank);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow, blank);
`else
    modport master (output start, bin_in, input busy, done, bcd_out, overflow);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BIN_TO_BCD_BLANK_EN adds a registered leading-zero blank output.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_WIDTH = 8,
    parameter int unsigned DIGITS    = 3
) (
    input logic             clk,
    input logic             reset,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH) + 1;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]       work_q, work_d;
    logic                   acc_q, acc_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;

    logic [BCD_W-1:0]       work_adj;
    logic [BCD_W-1:0]       work_shift;
    logic                   acc_shift;
    logic                   last_iter;

    assign last_iter = (count_q == CNT_W'(BIN_WIDTH - 1));

    // One dabble step: per-digit add-3, then shift the combined register left.
    always_comb begin : dabble_step
        work_adj = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        work_shift = {work_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        acc_shift  = acc_q | work_adj[BCD_W-1];
    end

    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_iter) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : output_comb
        bin_d   = bin_q;
        work_d  = work_q;
        acc_d   = acc_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d   = bus.bin_in;
                    work_d  = '0;
                    acc_d   = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                bin_d   = bin_q << 1;
                work_d  = work_shift;
                acc_d   = acc_shift;
                count_d = count_q + CNT_W'(1);
                if (last_iter) begin
                    bcd_d  = work_shift;
                    ovf_d  = acc_shift;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin : data_reg
        if (!reset) begin
            bin_q   <= '0;
            work_q  <= '0;
            acc_q   <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_nxt;
    logic              zero_above;

    // A digit blanks when it and everything above it are zero; units never blank.
    always_comb begin : blank_comb
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above   = zero_above & (work_shift[4*i +: 4] == 4'd0);
            blank_nxt[i] = (i != 0) && zero_above;
        end
    end

    always_ff @(posedge clk or negedge reset) begin : blank_reg
        if (!reset) begin
            blank_q <= '0;
        end else if (state_q == SHIFT && last_iter) begin
            blank_q <= blank_nxt;
        end
    end

    assign bus.blank = blank_q;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: 8-bit and 10-bit instances, directed vectors.
module tb_bin_to_bcd_seq;
    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q10[$];
    exp_t e8, e10;
    logic prev8, prev10;

    bin_to_bcd_seq_if #(.BIN_WIDTH(8),  .DIGITS(3)) bus8 ();
    bin_to_bcd_seq_if #(.BIN_WIDTH(10), .DIGITS(3)) bus10 ();

    bin_to_bcd_seq #(.BIN_WIDTH(8),  .DIGITS(3)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
    bin_to_bcd_seq #(.BIN_WIDTH(10), .DIGITS(3)) dut10 (.clk(clk), .reset(reset), .bus(bus10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors: compare on every done pulse, and enforce single-cycle done.
    always @(negedge clk) begin : mon8
        if (reset) begin
            if (prev8) check("done_pulse8", 32'(bus8.done), 32'd0);
            if (bus8.done) begin
                check("sb_nonempty8", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    e8 = q8.pop_front();
                    check("bcd8", 32'(bus8.bcd_out), 32'(e8.bcd));
                    check("ovf8", 32'(bus8.overflow), 32'(e8.ovf));
                    check("latency8", 32'(cyc), 32'(e8.cyc));
`ifdef BIN_TO_BCD_BLANK_EN
                    check("blank8", 32'(bus8.blank), 32'(e8.blank));
`endif
                end
            end
        end
        prev8 = bus8.done;
    end

    always @(negedge clk) begin : mon10
        if (reset) begin
            if (prev10) check("done_pulse10", 32'(bus10.done), 32'd0);
            if (bus10.done) begin
                check("sb_nonempty10", 32'(q10.size() != 0), 32'd1);
                if (q10.size() != 0) begin
                    e10 = q10.pop_front();
                    check("bcd10", 32'(bus10.bcd_out), 32'(e10.bcd));
                    check("ovf10", 32'(bus10.overflow), 32'(e10.ovf));
                    check("latency10", 32'(cyc), 32'(e10.cyc));
`ifdef BIN_TO_BCD_BLANK_EN
                    check("blank10", 32'(bus10.blank), 32'(e10.blank));
`endif
                end
            end
        end
        prev10 = bus10.done;
    end

    task automatic wait_idle8();
        int n = 0;
        while (bus8.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus8.busy) check("idle_timeout8", 32'(bus8.busy), 32'd0);
    endtask

    task automatic wait_idle10();
        int n = 0;
        while (bus10.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus10.busy) check("idle_timeout10", 32'(bus10.busy), 32'd0);
    endtask

    task automatic run8(input logic [7:0] v, input logic [11:0] b, input logic o, input logic [2:0] bl);
        wait_idle8();
        bus8.start  = 1'b1;
        bus8.bin_in = v;
        q8.push_back('{bcd: b, ovf: o, blank: bl, cyc: cyc + 1 + 8});
        @(negedge clk);
        bus8.start = 1'b0;
        check("busy8", 32'(bus8.busy), 32'd1);
    endtask

    task automatic run10(input logic [9:0] v, input logic [11:0] b, input logic o, input logic [2:0] bl);
        wait_idle10();
        bus10.start  = 1'b1;
        bus10.bin_in = v;
        q10.push_back('{bcd: b, ovf: o, blank: bl, cyc: cyc + 1 + 10});
        @(negedge clk);
        bus10.start = 1'b0;
        check("busy10", 32'(bus10.busy), 32'd1);
    endtask

    logic [7:0]  vin  [9] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128, 8'd7, 8'd42, 8'd105};
    logic [11:0] vbcd [9] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128, 12'h007, 12'h042, 12'h105};
    logic [2:0]  vblk [9] = '{3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000, 3'b110, 3'b100, 3'b000};

    initial begin
        cyc = 0; errors = 0; checks = 0;
        prev8 = 1'b0; prev10 = 1'b0;
        reset = 1'b0;
        bus8.start = 1'b0;  bus8.bin_in = '0;
        bus10.start = 1'b0; bus10.bin_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_bcd", 32'(bus8.bcd_out), 32'h000);
        check("rst_ovf", 32'(bus8.overflow), 32'd0);

        run8(8'd255, 12'h255, 1'b0, 3'b000);
        for (int i = 0; i < 9; i++) run8(vin[i], vbcd[i], 1'b0, vblk[i]);

        // Second start during conversion must be ignored.
        run8(8'd200, 12'h200, 1'b0, 3'b000);
        @(negedge clk);
        bus8.start  = 1'b1;
        bus8.bin_in = 8'd17;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_idle8();
        @(negedge clk);

        // Reset mid-conversion: abort with no done pulse.
        wait_idle8();
        bus8.start  = 1'b1;
        bus8.bin_in = 8'd200;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus8.busy), 32'd0);
        check("abort_done", 32'(bus8.done), 32'd0);
        check("abort_bcd", 32'(bus8.bcd_out), 32'h000);
        check("abort_ovf", 32'(bus8.overflow), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done_bcd", 32'(bus8.bcd_out), 32'h000);

        run10(10'd1023, 12'h023, 1'b1, 3'b100);
        run10(10'd999,  12'h999, 1'b0, 3'b000);
        run10(10'd5,    12'h005, 1'b0, 3'b110);

        for (int n = 0; n < 60 && (q8.size() + q10.size()) != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(q8.size() + q10.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
